// File: rtl/writeselect_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : writeselect_pipe                                            |
// | Description : Write-side register-file select pipeline. Decodes the       |
// |               destination register and write enable of each issued        |
// |               instruction, carries them DEPTH stages to write-back and    |
// |               drives the register-file write port. A 32-bit pending-write |
// |               scoreboard blocks issue on RAW and WAW hazards.             |
// | Parameters  : DEPTH        issue-to-writeback latency in stages (>= 1)    |
// | Ports       : clk          clock, all state updates on rising edge        |
// |               rst_n        asynchronous active-low reset                  |
// |               issue_valid  instruction presented for issue               |
// |               instructions instruction word being issued                 |
// |               readSelect1  source register 1 of presented instruction    |
// |               readSelect2  source register 2 of presented instruction    |
// |               flush        synchronous kill of all in-flight writes       |
// |               stall        combinational issue refusal                    |
// |               writeSelect  registered register-file write address        |
// |               writeEnable  registered register-file write strobe         |
// |               busy         pending-write scoreboard, bit i = reg i busy   |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module writeselect_pipe #(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [31:0] instructions,
    input  logic [4:0]  readSelect1,
    input  logic [4:0]  readSelect2,
    input  logic        flush,
    output logic        stall,
    output logic [4:0]  writeSelect,
    output logic        writeEnable,
    output logic [31:0] busy
);

    // Opcode classes that carry a destination field.
    localparam logic [2:0] c_OP_RD_LO  = 3'b000;  // dest in [15:11]
    localparam logic [2:0] c_OP_RD_MID = 3'b001;  // dest in [20:16]
    localparam logic [2:0] c_OP_RD_HI0 = 3'b010;  // dest in [25:21]
    localparam logic [2:0] c_OP_RD_HI1 = 3'b110;  // dest in [25:21]

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]      pipe_we_q;
    logic [DEPTH-1:0]      pipe_we_d;
    logic [DEPTH-1:0][4:0] pipe_dest_q;
    logic [DEPTH-1:0][4:0] pipe_dest_d;
    logic [31:0]           busy_q;
    logic [31:0]           busy_d;

    // ------------------------------------------------------------------
    // Destination decode
    // ------------------------------------------------------------------
    logic       w_has_dest;
    logic [4:0] w_raw_dest;
    logic       w_dec_we;
    logic [4:0] w_dec_dest;

    always_comb begin
        w_has_dest = 1'b0;
        w_raw_dest = 5'd0;
        case (instructions[31:29])
            c_OP_RD_LO: begin
                w_has_dest = 1'b1;
                w_raw_dest = instructions[15:11];
            end
            c_OP_RD_MID: begin
                w_has_dest = 1'b1;
                w_raw_dest = instructions[20:16];
            end
            c_OP_RD_HI0, c_OP_RD_HI1: begin
                w_has_dest = 1'b1;
                w_raw_dest = instructions[25:21];
            end
            default: begin
                w_has_dest = 1'b0;
                w_raw_dest = 5'd0;
            end
        endcase
    end

    // r0 is hard-wired, so a write to it is no write at all. The address is
    // zeroed too so non-writing entries travel as clean bubbles.
    assign w_dec_we   = w_has_dest & (w_raw_dest != 5'd0);
    assign w_dec_dest = w_dec_we ? w_raw_dest : 5'd0;

    // Remaining instruction bits play no part in write selection.
    logic w_unused_bits;
    assign w_unused_bits = ^{instructions[28:26], instructions[10:0]};

    // ------------------------------------------------------------------
    // Hazard detection and issue acceptance
    // ------------------------------------------------------------------
    logic w_raw_hit;
    logic w_waw_hit;
    logic w_accept;

    assign w_raw_hit = busy_q[readSelect1] | busy_q[readSelect2];
    assign w_waw_hit = w_dec_we & busy_q[w_dec_dest];
    assign stall     = issue_valid & (w_raw_hit | w_waw_hit);

    // flush does not feed stall; it only vetoes the acceptance.
    assign w_accept  = issue_valid & ~stall & ~flush;

    // ------------------------------------------------------------------
    // Write pipe next state
    // ------------------------------------------------------------------
    always_comb begin
        pipe_we_d   = '0;
        pipe_dest_d = '0;
        if (!flush) begin
            pipe_we_d[0]   = w_accept & w_dec_we;
            pipe_dest_d[0] = w_accept ? w_dec_dest : 5'd0;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_we_d[i]   = pipe_we_q[i-1];
                pipe_dest_d[i] = pipe_dest_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    logic [31:0] w_busy_set;
    logic [31:0] w_busy_clr;

    always_comb begin
        w_busy_set = '0;
        w_busy_clr = '0;
        busy_d     = busy_q;
        if (w_accept && w_dec_we) begin
            w_busy_set[w_dec_dest] = 1'b1;
        end
        // The entry in the last stage retires at this edge.
        if (pipe_we_q[DEPTH-1]) begin
            w_busy_clr[pipe_dest_q[DEPTH-1]] = 1'b1;
        end
        // Set is applied after clear so a same-edge collision keeps the bit.
        busy_d    = (busy_q & ~w_busy_clr) | w_busy_set;
        busy_d[0] = 1'b0;
        if (flush) begin
            busy_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_we_q   <= '0;
            pipe_dest_q <= '0;
            busy_q      <= '0;
        end else begin
            pipe_we_q   <= pipe_we_d;
            pipe_dest_q <= pipe_dest_d;
            busy_q      <= busy_d;
        end
    end

    // The last pipe stage is the register-file write port.
    assign writeEnable = pipe_we_q[DEPTH-1];
    assign writeSelect = pipe_dest_q[DEPTH-1];
    assign busy        = {busy_q[31:1], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_writeselect_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_writeselect_pipe                                         |
// | Description : Scoreboard bench for writeselect_pipe. A reference model    |
// |               records every accepted instruction by edge number and      |
// |               derives stall, write port and busy from those records.     |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_writeselect_pipe;

    localparam int DEPTH = 3;
    localparam int MAXE  = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [31:0] instructions;
    logic [4:0]  readSelect1;
    logic [4:0]  readSelect2;
    logic        flush;
    logic        stall;
    logic [4:0]  writeSelect;
    logic        writeEnable;
    logic [31:0] busy;

    writeselect_pipe #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .instructions (instructions),
        .readSelect1  (readSelect1),
        .readSelect2  (readSelect2),
        .flush        (flush),
        .stall        (stall),
        .writeSelect  (writeSelect),
        .writeEnable  (writeEnable),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        stall;
        logic        we;
        logic [4:0]  sel;
        logic        sel_chk;
        logic [31:0] busy;
    } exp_t;

    exp_t expq[$];

    // Model: what was accepted at each edge, and the last edge at which
    // everything in flight was killed (flush or reset).
    bit         acc_v    [MAXE];
    bit         acc_we   [MAXE];
    logic [4:0] acc_dest [MAXE];
    int         cur       = 0;
    int         last_kill = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void decode(input logic [31:0] ins, output bit we, output logic [4:0] d);
        logic [4:0] r;
        case (ins[31:29])
            3'b000:          r = ins[15:11];
            3'b001:          r = ins[20:16];
            3'b010, 3'b110:  r = ins[25:21];
            default:         r = 5'd0;
        endcase
        we = (r != 5'd0);
        d  = we ? r : 5'd0;
    endfunction

    function automatic bit live(input int e);
        return (e >= 1) && (e > last_kill) && acc_v[e];
    endfunction

    // A write accepted at edge e is pending after edges e .. e+DEPTH-1.
    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int e = cur - DEPTH + 1; e <= cur; e++) begin
            if (live(e) && acc_we[e]) b[acc_dest[e]] = 1'b1;
        end
        return b;
    endfunction

    // Build an instruction with the given opcode and register in its dest field.
    function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic [4:0] rd);
        logic [31:0] w = $urandom;
        w[31:29] = op;
        case (op)
            3'b000:          w[15:11] = rd;
            3'b001:          w[20:16] = rd;
            3'b010, 3'b110:  w[25:21] = rd;
            default:         w = w;
        endcase
        return w;
    endfunction

    // Drives one cycle: push expected response, then advance the model at the edge.
    task automatic cycle(input logic iv, input logic [31:0] ins,
                         input logic [4:0] r1, input logic [4:0] r2, input logic fl);
        exp_t        x;
        logic [31:0] b;
        bit          we;
        logic [4:0]  d;
        int          eo;
        bit          acc;
        issue_valid  = iv;
        instructions = ins;
        readSelect1  = r1;
        readSelect2  = r2;
        flush        = fl;
        b = model_busy();
        decode(ins, we, d);
        x.stall = iv & (b[r1] | b[r2] | (we & b[d]));
        eo = cur - DEPTH + 1;
        if (live(eo)) begin
            x.we      = acc_we[eo];
            x.sel     = acc_dest[eo];
            x.sel_chk = acc_we[eo];
        end else begin
            x.we      = 1'b0;
            x.sel     = 5'd0;
            x.sel_chk = 1'b1;
        end
        x.busy = b;
        expq.push_back(x);
        acc = iv && !x.stall && !fl;
        #3;
        // A new write must never target the register retiring at the same edge.
        if (acc && we) begin
            total++;
            if (writeEnable === 1'b1 && writeSelect === d) begin
                bad++;
                $display("FAIL set_clear_collision: reg %0d set while retiring at %0t", d, $time);
            end
        end
        @(posedge clk);
        cur++;
        acc_v[cur]    = acc;
        acc_we[cur]   = we;
        acc_dest[cur] = d;
        if (fl) last_kill = cur;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, after the monitor has sampled.
    task automatic async_reset();
        exp_t x;
        issue_valid  = 1'b1;
        instructions = 32'h0000_2800;
        readSelect1  = 5'd5;
        readSelect2  = 5'd0;
        flush        = 1'b0;
        x.stall   = model_busy()[5];
        x.we      = live(cur - DEPTH + 1) && acc_we[cur - DEPTH + 1];
        x.sel     = x.we ? acc_dest[cur - DEPTH + 1] : 5'd0;
        x.sel_chk = x.we || !live(cur - DEPTH + 1);
        x.busy    = model_busy();
        expq.push_back(x);
        #5;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy",  busy,        32'h0);
        chk("async_rst_we",    writeEnable, 32'h0);
        chk("async_rst_sel",   writeSelect, 32'h0);
        chk("async_rst_stall", stall,       32'h0);
        issue_valid = 1'b0;
        last_kill   = cur;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        cur++;
        acc_v[cur] = 1'b0;
        #1;
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("stall",       stall,       x.stall);
                chk("writeEnable", writeEnable, x.we);
                if (x.sel_chk) chk("writeSelect", writeSelect, x.sel);
                chk("busy",        busy,        x.busy);
            end
        end
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("FAIL watchdog: run did not complete, expected completion before %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n        = 1'b0;
        issue_valid  = 1'b0;
        instructions = 32'h0;
        readSelect1  = 5'd0;
        readSelect2  = 5'd0;
        flush        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  busy,        32'h0);
        chk("reset_we",    writeEnable, 32'h0);
        chk("reset_sel",   writeSelect, 32'h0);
        chk("reset_stall", stall,       32'h0);
        rst_n = 1'b1;

        // Single write to r5.
        cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        idle(5);
        // RAW against r5.
        cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h4005_0000, 5'd5, 5'd0, 1'b0);
        idle(4);
        // WAW: same dest presented until accepted twice.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        idle(8);
        // Non-writing instructions.
        cycle(1'b1, 32'h8000_0000, 5'd3, 5'd4, 1'b0);
        cycle(1'b1, 32'h0000_0000, 5'd0, 5'd0, 1'b0);
        idle(4);
        // Flush of three in-flight writes, then resume.
        cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 32'h0000_3000, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 32'h0000_3800, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 32'h0, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        idle(5);
        // Asynchronous reset with r5..r7 pending.
        cycle(1'b1, 32'h0000_2800, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 32'h0000_3000, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 32'h0000_3800, 5'd0, 5'd0, 1'b0);
        async_reset();
        idle(3);

        // Random traffic over a small register range to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            logic        iv;
            logic [2:0]  op;
            logic [4:0]  rd;
            logic        fl;
            iv = ($urandom_range(0, 9) < 7);
            op = 3'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            fl = ($urandom_range(0, 99) < 3);
            if (i % 400 == 399) begin
                async_reset();
            end else begin
                cycle(iv, mk_instr(op, rd), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), fl);
            end
        end
        idle(DEPTH + 2);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", expq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
